// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, issues one imem request at a time and hands fetched PCs to decode.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirects to TRAP_VEC instead of masking the low bits.
module pc_sequencer #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
   parameter int unsigned      STEP      = 4,
   parameter logic [WIDTH-1:0] TRAP_VEC  = 32'h0000_0100
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   output logic             instr_valid,
   output logic [WIDTH-1:0] instr_pc,
   input  logic             instr_ready,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic             halt,
   input  logic             resume,
   output logic             halted,
   output logic             trap
);

`ifdef PC_ALIGN_CHECK_EN
   typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALTED, S_TRAP} state_t;
`else
   typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALTED} state_t;
`endif

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_pc, w_pc_nxt;
   logic             r_req, w_req_nxt;
   logic [WIDTH-1:0] r_addr, w_addr_nxt;
   logic             r_valid, w_valid_nxt;
   logic [WIDTH-1:0] r_instr_pc, w_instr_pc_nxt;
   logic             r_halted, w_halted_nxt;
   logic             r_flush, w_flush_nxt;
   logic             r_halt_pend, w_halt_pend_nxt;
   logic [WIDTH-1:0] w_target;

`ifdef PC_ALIGN_CHECK_EN
   logic r_trap, w_trap_nxt;
   logic r_trap_pend, w_trap_pend_nxt;
   logic w_misaligned;

   assign w_misaligned = |redirect_target[1:0];
   assign w_target     = redirect_target;
`else
   localparam logic [WIDTH-1:0] ALIGN_MASK = (STEP == 4) ? WIDTH'(3) : '0;

   assign w_target = redirect_target & ~ALIGN_MASK;
`endif

   always_comb begin
      // NOTE: every next-state value is defaulted first so no path through the case infers a latch.
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_req_nxt       = r_req;
      w_addr_nxt      = r_addr;
      w_valid_nxt     = r_valid;
      w_instr_pc_nxt  = r_instr_pc;
      w_halted_nxt    = r_halted;
      w_flush_nxt     = r_flush;
      w_halt_pend_nxt = r_halt_pend | halt;
`ifdef PC_ALIGN_CHECK_EN
      w_trap_nxt      = 1'b0;
      w_trap_pend_nxt = r_trap_pend;
`endif

      // A redirect retargets the PC in every state; the case below adds the per-state side effects.
      if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
         w_trap_pend_nxt = w_misaligned;
         if (!w_misaligned)
`endif
         w_pc_nxt = w_target;
      end

      case (r_state)
         S_FETCH: begin
            if (r_req) begin
               if (redirect) begin
                  // A same-cycle ack is treated as already flushed.
                  w_flush_nxt = !imem_ack;
                  w_req_nxt   = !imem_ack;
               end else if (imem_ack) begin
                  w_req_nxt = 1'b0;
                  if (r_flush) begin
                     w_flush_nxt = 1'b0;
                  end else begin
                     w_instr_pc_nxt = r_addr;
                     w_valid_nxt    = 1'b1;
                     w_pc_nxt       = r_addr + STEP_W;
                     w_state_nxt    = S_HOLD;
                  end
               end
            end else if (!redirect) begin
               if (r_halt_pend) begin
                  w_state_nxt     = S_HALTED;
                  w_halted_nxt    = 1'b1;
                  w_halt_pend_nxt = 1'b0;
               end else begin
                  w_req_nxt  = 1'b1;
                  w_addr_nxt = r_pc;
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = S_FETCH;
            end else if (instr_ready) begin
               w_valid_nxt = 1'b0;
               if (r_halt_pend) begin
                  w_state_nxt     = S_HALTED;
                  w_halted_nxt    = 1'b1;
                  w_halt_pend_nxt = 1'b0;
               end else begin
                  w_state_nxt = S_FETCH;
               end
            end
         end
         S_HALTED: begin
            w_halt_pend_nxt = 1'b0;
            if (!redirect && resume && !halt) begin
               w_state_nxt  = S_FETCH;
               w_halted_nxt = 1'b0;
            end
         end
`ifdef PC_ALIGN_CHECK_EN
         S_TRAP: begin
            w_pc_nxt    = TRAP_VEC;
            w_state_nxt = S_FETCH;
         end
`endif
         default: w_state_nxt = S_FETCH;
      endcase

`ifdef PC_ALIGN_CHECK_EN
      // A pending trap waits for any outstanding request to drain before taking over.
      if (w_trap_pend_nxt && !w_req_nxt) begin
         w_state_nxt     = S_TRAP;
         w_trap_nxt      = 1'b1;
         w_trap_pend_nxt = 1'b0;
         w_valid_nxt     = 1'b0;
         w_halted_nxt    = 1'b0;
         w_flush_nxt     = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (rst) begin
         r_state     <= S_FETCH;
         r_pc        <= RESET_VEC;
         r_req       <= 1'b0;
         r_addr      <= RESET_VEC;
         r_valid     <= 1'b0;
         r_instr_pc  <= '0;
         r_halted    <= 1'b0;
         r_flush     <= 1'b0;
         r_halt_pend <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
         r_trap      <= 1'b0;
         r_trap_pend <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_req       <= w_req_nxt;
         r_addr      <= w_addr_nxt;
         r_valid     <= w_valid_nxt;
         r_instr_pc  <= w_instr_pc_nxt;
         r_halted    <= w_halted_nxt;
         r_flush     <= w_flush_nxt;
         r_halt_pend <= w_halt_pend_nxt;
`ifdef PC_ALIGN_CHECK_EN
         r_trap      <= w_trap_nxt;
         r_trap_pend <= w_trap_pend_nxt;
`endif
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign instr_valid = r_valid;
   assign instr_pc    = r_instr_pc;
   assign halted      = r_halted;
`ifdef PC_ALIGN_CHECK_EN
   assign trap        = r_trap;
`else
   assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, decode stall, flushed redirect, halt/resume,
// misaligned redirect and PC wrap-around on a second instance reset to 32'hFFFF_FFF8.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        instr_valid;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        halt;
   logic        resume;
   logic        halted;
   logic        trap;

   logic        rst_w;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ack;
   logic        w_valid;
   logic [31:0] w_ipc;
   logic        w_halted;
   logic        w_trap;
   logic        tie_one;
   logic        tie_zero;
   logic [31:0] tie_zero_w;

   int n_vec;
   int n_err;

   pc_sequencer dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .instr_valid     (instr_valid),
      .instr_pc        (instr_pc),
      .instr_ready     (instr_ready),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .halt            (halt),
      .resume          (resume),
      .halted          (halted),
      .trap            (trap)
   );

   pc_sequencer #(.RESET_VEC(32'hFFFF_FFF8)) dut_wrap (
      .clk             (clk),
      .rst             (rst_w),
      .imem_req        (w_req),
      .imem_addr       (w_addr),
      .imem_ack        (w_ack),
      .instr_valid     (w_valid),
      .instr_pc        (w_ipc),
      .instr_ready     (tie_one),
      .redirect        (tie_zero),
      .redirect_target (tie_zero_w),
      .halt            (tie_zero),
      .resume          (tie_zero),
      .halted          (w_halted),
      .trap            (w_trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_req(input string tag);
      for (int i = 0; i < 8 && imem_req !== 1'b1; i++) step();
      check(tag, {31'd0, imem_req}, 32'd1);
   endtask

   task automatic ack_once();
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
   endtask

   logic [31:0] wrap_exp [3];
   logic [31:0] trap_exp_addr;

   initial begin
      n_vec           = 0;
      n_err           = 0;
      rst             = 1'b1;
      rst_w           = 1'b1;
      imem_ack        = 1'b0;
      instr_ready     = 1'b1;
      redirect        = 1'b0;
      redirect_target = 32'd0;
      halt            = 1'b0;
      resume          = 1'b0;
      w_ack           = 1'b0;
      tie_one         = 1'b1;
      tie_zero        = 1'b0;
      tie_zero_w      = 32'd0;
      wrap_exp[0]     = 32'hFFFF_FFF8;
      wrap_exp[1]     = 32'hFFFF_FFFC;
      wrap_exp[2]     = 32'h0000_0000;

      // Reset state
      step();
      check("rst_valid_a", {31'd0, instr_valid}, 32'd0);
      check("rst_req_a", {31'd0, imem_req}, 32'd0);
      step();
      check("rst_valid_b", {31'd0, instr_valid}, 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_trap", {31'd0, trap}, 32'd0);
      rst = 1'b0;

      // Fetch 0 with single-cycle ack and ready high
      wait_req("req_0");
      check("addr_0", imem_addr, 32'h0);
      ack_once();
      check("valid_0", {31'd0, instr_valid}, 32'd1);
      check("ipc_0", instr_pc, 32'h0);
      check("req_drop_0", {31'd0, imem_req}, 32'd0);
      step();
      check("consume_0", {31'd0, instr_valid}, 32'd0);

      // Fetch 4, halt during HOLD, then resume
      instr_ready = 1'b0;
      wait_req("req_4");
      check("addr_4", imem_addr, 32'h4);
      ack_once();
      check("valid_4", {31'd0, instr_valid}, 32'd1);
      check("ipc_4", instr_pc, 32'h4);
      halt = 1'b1;
      step();
      halt = 1'b0;
      check("hold4_valid", {31'd0, instr_valid}, 32'd1);
      check("hold4_not_halted", {31'd0, halted}, 32'd0);
      instr_ready = 1'b1;
      step();
      check("halted_set", {31'd0, halted}, 32'd1);
      check("halted_valid", {31'd0, instr_valid}, 32'd0);
      check("halted_req", {31'd0, imem_req}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("halted_stay", {31'd0, halted}, 32'd1);
         check("halted_no_req", {31'd0, imem_req}, 32'd0);
      end
      halt   = 1'b1;
      resume = 1'b1;
      step();
      halt = 1'b0;
      check("halt_beats_resume", {31'd0, halted}, 32'd1);
      step();
      resume = 1'b0;
      check("resumed", {31'd0, halted}, 32'd0);

      // Fetch 8 with decode stalled for 5 cycles
      instr_ready = 1'b0;
      wait_req("req_8");
      check("addr_8", imem_addr, 32'h8);
      ack_once();
      check("valid_8", {31'd0, instr_valid}, 32'd1);
      check("ipc_8", instr_pc, 32'h8);
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_ipc", instr_pc, 32'h8);
         check("stall_no_req", {31'd0, imem_req}, 32'd0);
      end
      instr_ready = 1'b1;
      step();
      check("consume_8", {31'd0, instr_valid}, 32'd0);

      // Fetch C redirected to 40 while outstanding; ack two cycles later is discarded
      wait_req("req_c");
      check("addr_c", imem_addr, 32'hC);
      redirect        = 1'b1;
      redirect_target = 32'h40;
      step();
      redirect = 1'b0;
      check("flush_req_hold", {31'd0, imem_req}, 32'd1);
      check("flush_addr_hold", imem_addr, 32'hC);
      step();
      check("flush_addr_hold2", imem_addr, 32'hC);
      check("flush_no_valid", {31'd0, instr_valid}, 32'd0);
      ack_once();
      check("flushed_no_valid", {31'd0, instr_valid}, 32'd0);
      check("flushed_req_drop", {31'd0, imem_req}, 32'd0);
      wait_req("req_40");
      check("addr_40", imem_addr, 32'h40);
      check("req40_no_valid", {31'd0, instr_valid}, 32'd0);
      instr_ready = 1'b0;
      ack_once();
      check("valid_40", {31'd0, instr_valid}, 32'd1);
      check("ipc_40", instr_pc, 32'h40);

      // Misaligned redirect from HOLD, same-cycle ready ignored
      redirect        = 1'b1;
      redirect_target = 32'h42;
      instr_ready     = 1'b1;
      step();
      redirect = 1'b0;
      check("redir_drop_valid", {31'd0, instr_valid}, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
      check("trap_pulse", {31'd0, trap}, 32'd1);
      step();
      check("trap_clear", {31'd0, trap}, 32'd0);
      trap_exp_addr = 32'h100;
`else
      check("trap_tied_low", {31'd0, trap}, 32'd0);
      trap_exp_addr = 32'h40;
`endif
      wait_req("req_after_misaligned");
      check("addr_after_misaligned", imem_addr, trap_exp_addr);
      ack_once();
      check("ipc_after_misaligned", instr_pc, trap_exp_addr);
      step();

      // PC wrap-around on the second instance
      rst_w = 1'b0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 8 && w_req !== 1'b1; i++) step();
         check("wrap_req", {31'd0, w_req}, 32'd1);
         check("wrap_addr", w_addr, wrap_exp[k]);
         w_ack = 1'b1;
         step();
         w_ack = 1'b0;
         check("wrap_valid", {31'd0, w_valid}, 32'd1);
         check("wrap_ipc", w_ipc, wrap_exp[k]);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
